// File: rtl/pulse_tx_pkg.sv
// rtl/pulse_tx_pkg.sv - shared state encoding, timing defaults and drive-window helpers for pulse_tx
// Contents:
//   state_t           IDLE / BURST / HOLD encoding
//   DEF_*             default timing constants, also the source for receive-side delays
//   drive_p / drive_n phase-window decode for the two transducer drives
package pulse_tx_pkg;

    localparam int CNT_W = 20;

    localparam int unsigned DEF_HALF_CNT = 100;
    localparam int unsigned DEF_DEAD     = 4;
    localparam int unsigned DEF_NCYC     = 4;
    localparam int unsigned DEF_HOLDOFF  = 65200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Positive drive owns the first half-period minus its leading dead band.
    function automatic logic drive_p(input logic [CNT_W-1:0] phase,
                                     input int unsigned half,
                                     input int unsigned dead);
        return (phase >= CNT_W'(dead)) && (phase < CNT_W'(half));
    endfunction

    // Negative drive owns the second half-period minus its leading dead band.
    function automatic logic drive_n(input logic [CNT_W-1:0] phase,
                                     input int unsigned half,
                                     input int unsigned dead);
        return (phase >= CNT_W'(half + dead)) && (phase < CNT_W'(2 * half));
    endfunction

endpackage

// File: rtl/pulse_phase_gen.sv
// rtl/pulse_phase_gen.sv - phase counter with dead-band compare producing registered Tx_p/Tx_n
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          restart the phase at 0 with both drives low
//   i_advance        step the phase by one (wrapping at 2*HALF_CNT-1)
//   o_phase_last     current phase is the last of the period
//   o_tx_p, o_tx_n   registered drives for the current phase
module pulse_phase_gen
    import pulse_tx_pkg::*;
#(
    parameter int unsigned HALF_CNT = DEF_HALF_CNT,
    parameter int unsigned DEAD     = DEF_DEAD
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_phase_last,
    output logic o_tx_p,
    output logic o_tx_n
);

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(2 * HALF_CNT - 1);

    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] w_phase_next;
    logic             w_tx_p_next;
    logic             w_tx_n_next;

    assign o_phase_last = (r_phase == P_LAST);

    // Drives are decoded from the phase the next cycle will hold, so the
    // registered outputs line up with r_phase. Anything other than an advance
    // (idle, holdoff, clear) leaves both drives low.
    always_comb begin
        w_phase_next = r_phase;
        w_tx_p_next  = 1'b0;
        w_tx_n_next  = 1'b0;
        if (i_clear) begin
            w_phase_next = '0;
        end else if (i_advance) begin
            w_phase_next = o_phase_last ? '0 : r_phase + CNT_W'(1);
            w_tx_p_next  = drive_p(w_phase_next, HALF_CNT, DEAD);
            w_tx_n_next  = drive_n(w_phase_next, HALF_CNT, DEAD);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            o_tx_p  <= 1'b0;
            o_tx_n  <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            o_tx_p  <= w_tx_p_next;
            o_tx_n  <= w_tx_n_next;
        end
    end

endmodule

// File: rtl/pulse_tx.sv
// rtl/pulse_tx.sv - ultrasound excitation burst generator with dead band, holdoff and abort
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          burst request (accepted only while not busy)
//   i_abort          terminate burst/holdoff at once, no done pulse
//   o_tx_p, o_tx_n   complementary transducer drives, never high together
//   o_tx_sync        one-cycle marker in burst cycle 0
//   o_tx_busy        high from burst cycle 0 through the last holdoff cycle
//   o_tx_done        one-cycle pulse in the first cycle after holdoff
module pulse_tx
    import pulse_tx_pkg::*;
#(
    parameter int unsigned HALF_CNT = DEF_HALF_CNT,
    parameter int unsigned DEAD     = DEF_DEAD,
    parameter int unsigned NCYC     = DEF_NCYC,
    parameter int unsigned HOLDOFF  = DEF_HOLDOFF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_abort,
    output logic o_tx_p,
    output logic o_tx_n,
    output logic o_tx_sync,
    output logic o_tx_busy,
    output logic o_tx_done
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCYC - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLDOFF - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] w_cyc_next;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_next;
    logic             w_sync_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_clear;
    logic             w_advance;
    logic             w_phase_last;

    pulse_phase_gen #(
        .HALF_CNT (HALF_CNT),
        .DEAD     (DEAD)
    ) u_phase (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_advance    (w_advance),
        .o_phase_last (w_phase_last),
        .o_tx_p       (o_tx_p),
        .o_tx_n       (o_tx_n)
    );

    // Status outputs are decoded from the next state so that, once
    // registered, they describe the cycle the FSM is actually in.
    always_comb begin
        w_state_next = r_state;
        w_cyc_next   = r_cyc;
        w_hold_next  = r_hold;
        w_sync_next  = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        w_clear      = 1'b0;
        w_advance    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Abort wins over a simultaneous start.
                if (i_start && !i_abort) begin
                    w_state_next = ST_BURST;
                    w_cyc_next   = '0;
                    w_hold_next  = '0;
                    w_sync_next  = 1'b1;
                    w_busy_next  = 1'b1;
                    w_clear      = 1'b1;
                end
            end

            ST_BURST: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_cyc_next   = '0;
                    w_hold_next  = '0;
                    w_clear      = 1'b1;
                end else begin
                    w_advance   = 1'b1;
                    w_busy_next = 1'b1;
                    if (w_phase_last) begin
                        if (r_cyc == C_LAST) begin
                            w_state_next = ST_HOLD;
                            w_cyc_next   = '0;
                            w_hold_next  = '0;
                        end else begin
                            w_cyc_next = r_cyc + CNT_W'(1);
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_cyc_next   = '0;
                    w_hold_next  = '0;
                    w_clear      = 1'b1;
                end else if (r_hold == H_LAST) begin
                    // Return to IDLE now so a start during the done cycle is taken.
                    w_state_next = ST_IDLE;
                    w_hold_next  = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_hold_next = r_hold + CNT_W'(1);
                    w_busy_next = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cyc_next   = '0;
                w_hold_next  = '0;
                w_clear      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cyc     <= '0;
            r_hold    <= '0;
            o_tx_sync <= 1'b0;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cyc     <= w_cyc_next;
            r_hold    <= w_hold_next;
            o_tx_sync <= w_sync_next;
            o_tx_busy <= w_busy_next;
            o_tx_done <= w_done_next;
        end
    end

endmodule

// File: tb/tb_pulse_tx.sv
// tb/tb_pulse_tx.sv - self-checking bench for pulse_tx
module tb_pulse_tx;

    localparam int H    = 10;
    localparam int D    = 2;
    localparam int N    = 3;
    localparam int HO   = 20;
    localparam int BLEN = 2 * H * N;
    localparam int TOT  = BLEN + HO;

    typedef struct {
        int         cyc;
        logic       start;
        logic       abort;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic tx_p, tx_n, tx_sync, tx_busy, tx_done;
    logic [4:0] w_out;

    int n_checks = 0;
    int n_pass   = 0;
    int age      = -1;

    vec_t tbl[$];

    assign w_out = {tx_p, tx_n, tx_sync, tx_busy, tx_done};

    always #5 clk = ~clk;

    pulse_tx #(
        .HALF_CNT (H),
        .DEAD     (D),
        .NCYC     (N),
        .HOLDOFF  (HO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_abort   (abort),
        .o_tx_p    (tx_p),
        .o_tx_n    (tx_n),
        .o_tx_sync (tx_sync),
        .o_tx_busy (tx_busy),
        .o_tx_done (tx_done)
    );

    always @(negedge clk) begin
        n_checks++;
        assert (!(tx_p && tx_n)) n_pass++;
        else $display("FAIL overlap: tx_p=%b tx_n=%b at %0t", tx_p, tx_n, $time);
    end

    // Reference: age = cycles since burst cycle 0, -1 when nothing pending.
    function automatic logic [4:0] model_exp();
        int ph;
        if (age < 0 || age > TOT) return 5'b00000;
        if (age == TOT) return 5'b00001;
        if (age >= BLEN) return 5'b00010;
        ph = age % (2 * H);
        return {(ph >= D && ph < H), (ph >= H + D), (age == 0), 1'b1, 1'b0};
    endfunction

    function automatic void model_step(input logic s, input logic a, input logic r);
        bit busy_before;
        busy_before = (age >= 0 && age < TOT);
        if (!r) age = -1;
        else if (a && busy_before) age = -1;
        else if (!busy_before && s && !a) age = 0;
        else if (age >= 0) begin
            age++;
            if (age > TOT) age = -1;
        end
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (p,n,sync,busy,done)", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(start, abort, rst_n);
        #1;
        check("model", w_out, model_exp());
    endtask

    task automatic drain();
        int k;
        start = 1'b0;
        abort = 1'b0;
        k = 0;
        while ((age >= 0 || w_out != 5'b0) && k < 300) begin
            tick();
            k++;
        end
        check_int("drain_timeout", (k < 300) ? 1 : 0, 1);
    endtask

    task automatic add(input int c, input logic [4:0] e);
        vec_t v;
        v.cyc = c; v.start = 1'b0; v.abort = 1'b0; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        int cur;
        start = 1'b1;
        tick();
        start = 1'b0;
        cur = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            while (cur < tbl[i].cyc) begin
                tick();
                cur++;
            end
            check($sformatf("%s_c%0d", tag, tbl[i].cyc), w_out, tbl[i].exp);
            start = tbl[i].start;
            abort = tbl[i].abort;
        end
        drain();
    endtask

    initial begin
        int k, syncs, done_at, dones, rst_cnt;
        int sync_at[$];

        add(0, 5'b00110);  add(1, 5'b00010);  add(2, 5'b10010);  add(9, 5'b10010);
        add(10, 5'b00010); add(11, 5'b00010); add(12, 5'b01010); add(19, 5'b01010);
        add(20, 5'b00010); add(21, 5'b00010); add(22, 5'b10010); add(29, 5'b10010);
        add(30, 5'b00010); add(32, 5'b01010); add(42, 5'b10010); add(49, 5'b10010);
        add(52, 5'b01010); add(59, 5'b01010); add(60, 5'b00010); add(79, 5'b00010);
        add(80, 5'b00001); add(81, 5'b00000);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", w_out, 5'b00000);
        rst_n = 1'b1;
        tick();
        tick();

        run_table("single");

        // Start pulses during the burst and during holdoff are dropped.
        start = 1'b1;
        tick();
        syncs = 0; done_at = -1;
        for (k = 0; k < 85; k++) begin
            if (k > 0 && tx_sync) syncs++;
            if (tx_done && done_at < 0) done_at = k;
            start = (k == 5 || k == 70);
            tick();
        end
        start = 1'b0;
        check_int("ignored_start_sync", syncs, 0);
        check_int("ignored_start_done", done_at, 80);
        drain();

        // Abort in the middle of a positive half-period.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 25; k++) tick();
        check("pre_abort_c25", w_out, 5'b10010);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_c26", w_out, 5'b00000);
        dones = 0;
        for (k = 0; k < 100; k++) begin
            tick();
            if (tx_done) dones++;
        end
        check_int("abort_no_done", dones, 0);
        run_table("post_abort");

        // Abort and start together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_wins", w_out, 5'b00000);
        tick();

        // Start held high: back-to-back bursts, one every TOT+1 cycles.
        start = 1'b1;
        for (k = 0; k < 250; k++) begin
            tick();
            if (tx_sync) sync_at.push_back(k);
        end
        start = 1'b0;
        check_int("held_start_count", sync_at.size(), 4);
        for (int i = 0; i < sync_at.size() && i < 4; i++)
            check_int($sformatf("held_start_sync%0d", i), sync_at[i], i * (TOT + 1));
        drain();

        // Reset while Tx_p is high.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 23; k++) tick();
        check("pre_reset_c23", w_out, 5'b10010);
        rst_n = 1'b0;
        #1;
        check("reset_async", w_out, 5'b00000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", w_out, 5'b00000);
        run_table("post_reset");

        // Random stimulus against the reference model.
        rst_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 299) == 0);
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 1999) == 0) begin
                rst_n = 1'b0;
                rst_cnt = 2;
                #1;
                check("rand_reset_async", w_out, 5'b00000);
            end
        end
        rst_n = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
